sar_compare_search: RTL and testbench
=====================================

Name: sar_compare_search

Overview:
- Successive-approximation searcher that initiates compare requests toward the team's 8-bit magnitude comparator.
- Drives a trial value onto the comparator's A input, with the hidden target on its B input.
- Reads back the 3-bit relation code and binary-searches the target value MSB-first.
- Consumer of comparator results; sits beside the comparator in lab top-levels and benches.

Parameters:
- WIDTH, 8: operand width in bits; legal range 2..15.
- CMP_LAT, 1: cycles each trial value is held before iCmp is sampled; legal range 1..15. Use 1 for a purely combinational comparator.

Ports:
- iClk  input  1  clock; all state updates on rising edge.
- iRst  input  1  synchronous, active-high reset.
- iStart  input  1  start request; sampled only in IDLE.
- iCmp  input  3  relation code for oGuess vs target: [2]=A>B, [1]=A==B, [0]=A<B; must be one-hot.
- oGuess  output  WIDTH  current trial value; drives comparator A.
- oBusy  output  1  high in TRY.
- oDone  output  1  one-cycle pulse, high in DONE.
- oResult  output  WIDTH  found value; valid while oDone is high and held afterwards.
- oSteps  output  4  number of comparisons used in the last search.
- oErr  output  1  last search aborted on an invalid iCmp code.

Behaviour:
- Interface: one clock, iClk. Reset iRst is synchronous and active-high.
- Reset values: state=IDLE; oGuess=0, oBusy=0, oDone=0, oResult=0, oSteps=0, oErr=0. Reset asserted mid-search aborts immediately; no oDone pulse.
- States: IDLE, TRY, DONE.
- IDLE:
  - iStart=1 -> TRY.
  - On that edge: oGuess=1<<(WIDTH-1), bit pointer=WIDTH-1, wait counter=CMP_LAT-1, oSteps=0, oErr=0.
  - iStart in TRY or DONE is ignored.
- TRY, wait counter != 0: decrement the counter; oGuess held.
- TRY, wait counter == 0: sample iCmp, oSteps+=1, then:
  - LT (guess<target): keep the pointer bit.
  - GT: clear the pointer bit.
  - EQ: keep the pointer bit; if early exit is enabled -> DONE, oResult=oGuess.
  - Not one-hot (000, 011, 111, ...): oErr=1, oResult=0 -> DONE.
  - Otherwise, pointer==0 -> DONE with oResult=updated value.
  - Otherwise, oGuess=updated | (1<<(pointer-1)), pointer-=1, counter=CMP_LAT-1.
- DONE: oDone=1 for exactly one cycle -> IDLE.
- Hold rules: oGuess, oResult, oSteps and oErr hold until the next accepted iStart. oErr clears on iStart.
- Latency, no early exit: oDone high exactly 1+WIDTH*CMP_LAT cycles after the iStart sampling edge. For WIDTH=8, CMP_LAT=1: cycle 9.
- Without early exit, an EQ trial keeps its bit; the lower trials all return GT and are cleared, so the final value is exact for every target.
- oSteps saturates at WIDTH. oBusy=1 exactly while in TRY.

Optional Feature:
- Macro: SAR_EARLY_EXIT_EN.
- Defined: an EQ result ends the search at that trial.
  - oSteps = number of trials actually run.
  - oDone at 1+oSteps*CMP_LAT cycles.
- Undefined: EQ is treated as LT for bit retention. Every search runs exactly WIDTH trials.
- Result value is identical in both builds.

Decomposition:
- Shared package holds:
  - relation code constants CMP_GT=3'b100, CMP_EQ=3'b010, CMP_LT=3'b001;
  - state encoding IDLE/TRY/DONE;
  - a one-hot check function used by the searcher and benches.
- No sub-module: the mask/pointer logic is too small to justify one. The bench pairs this block with the existing 8-bit comparator.

Test Plan:
- Target 8'h00, no early exit, CMP_LAT=1 -> trials 80,40,...,01 all return GT; oResult=00, oSteps=8, oDone in cycle 9.
- Target 8'hFF -> all trials return LT; oResult=FF, oSteps=8. Target 8'h5A -> guess sequence 80,40,60,50,58,5C,5A,5B; oResult=5A.
- SAR_EARLY_EXIT_EN defined:
  - target 8'h80 -> first trial EQ; oSteps=1, oDone in cycle 2, oResult=80;
  - target 8'h01 -> oSteps=8.
- CMP_LAT=3, target 8'h3C -> each oGuess held 3 cycles; oDone in cycle 25; oResult=3C.
- Force iCmp=3'b000 on the third trial -> oErr=1, oResult=00, oSteps=3, oDone pulse. Next iStart clears oErr.
- Assert iStart mid-search -> ignored. Assert iRst in the fourth trial -> all outputs 0 next cycle; IDLE; no oDone pulse.

Source files
------------

// File: rtl/sar_compare_search_pkg.sv
// Shared definitions for the SAR searcher and its benches: comparator relation
// codes, searcher state encoding and a relation-code validity check.
package sar_compare_search_pkg;

    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_LT = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TRY  = 2'd1,
        DONE = 2'd2
    } sarState_t;

    function automatic logic isOneHot(input logic [2:0] code);
        return (code == CMP_GT) || (code == CMP_EQ) || (code == CMP_LT);
    endfunction

endpackage

// File: rtl/sar_compare_search.sv
// MSB-first successive-approximation search against an external magnitude comparator.
// Optional macro SAR_EARLY_EXIT_EN: an EQ relation ends the search at that trial.
module sar_compare_search
    import sar_compare_search_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int CMP_LAT = 1
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStart,
    input  logic [2:0]       iCmp,
    output logic [WIDTH-1:0] oGuess,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oResult,
    output logic [3:0]       oSteps,
    output logic             oErr
);

    localparam logic [3:0]       TOP_PTR    = 4'(WIDTH - 1);
    localparam logic [3:0]       LAT_RELOAD = 4'(CMP_LAT - 1);
    localparam logic [3:0]       MAX_STEPS  = 4'(WIDTH);
    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

    sarState_t        state, stateNext;
    logic [3:0]       ptr, ptrNext;
    logic [3:0]       waitCnt, waitNext;
    logic [WIDTH-1:0] guessNext, resultNext, ptrMask, updated;
    logic [3:0]       stepsNext;
    logic             errNext;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state   <= IDLE;
            ptr     <= '0;
            waitCnt <= '0;
            oGuess  <= '0;
            oResult <= '0;
            oSteps  <= '0;
            oErr    <= 1'b0;
        end else begin
            state   <= stateNext;
            ptr     <= ptrNext;
            waitCnt <= waitNext;
            oGuess  <= guessNext;
            oResult <= resultNext;
            oSteps  <= stepsNext;
            oErr    <= errNext;
        end
    end

    always_comb begin
        stateNext  = state;
        ptrNext    = ptr;
        waitNext   = waitCnt;
        guessNext  = oGuess;
        resultNext = oResult;
        stepsNext  = oSteps;
        errNext    = oErr;
        ptrMask    = ONE << ptr;
        // GT means the trial overshot, so the bit under test is dropped; LT and EQ keep it
        updated    = (iCmp == CMP_GT) ? (oGuess & ~ptrMask) : oGuess;

        unique case (state)
            IDLE: begin
                if (iStart) begin
                    stateNext = TRY;
                    guessNext = ONE << TOP_PTR;
                    ptrNext   = TOP_PTR;
                    waitNext  = LAT_RELOAD;
                    stepsNext = '0;
                    errNext   = 1'b0;
                end
            end
            TRY: begin
                if (waitCnt != 4'd0) begin
                    waitNext = waitCnt - 4'd1;
                end else begin
                    if (oSteps < MAX_STEPS) stepsNext = oSteps + 4'd1;
                    if (!isOneHot(iCmp)) begin
                        errNext    = 1'b1;
                        resultNext = '0;
                        stateNext  = DONE;
`ifdef SAR_EARLY_EXIT_EN
                    end else if (iCmp == CMP_EQ) begin
                        resultNext = oGuess;
                        stateNext  = DONE;
`endif
                    end else if (ptr == 4'd0) begin
                        resultNext = updated;
                        stateNext  = DONE;
                    end else begin
                        guessNext = updated | (ptrMask >> 1);
                        ptrNext   = ptr - 4'd1;
                        waitNext  = LAT_RELOAD;
                    end
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign oBusy = (state == TRY);
    assign oDone = (state == DONE);

endmodule

// File: tb/tb_sar_compare_search.sv
// Directed bench: two searchers (CMP_LAT=1 and CMP_LAT=3) each paired with a
// behavioural 8-bit comparator; table vectors plus error/restart/reset sequences.
module tb_sar_compare_search;
    import sar_compare_search_pkg::*;

`ifdef SAR_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, start1, start3, badCmp, sel;
    logic [7:0] tgt;
    logic [2:0] cmp1, cmp3;
    logic [7:0] g1, g3, r1, r3, gS, rS;
    logic [3:0] s1, s3, sS;
    logic       b1, b3, d1, d3, e1, e3, bS, dS, eS;
    int         tests = 0;
    int         fails = 0;
    logic [7:0] guessLog[$];

    always #5 clk = ~clk;

    function automatic logic [2:0] cmpModel(input logic [7:0] a, input logic [7:0] b);
        return {a > b, a == b, a < b};
    endfunction

    assign cmp1 = badCmp ? 3'b000 : cmpModel(g1, tgt);
    assign cmp3 = cmpModel(g3, tgt);
    assign gS = sel ? g3 : g1;
    assign rS = sel ? r3 : r1;
    assign sS = sel ? s3 : s1;
    assign bS = sel ? b3 : b1;
    assign dS = sel ? d3 : d1;
    assign eS = sel ? e3 : e1;

    sar_compare_search #(.WIDTH(8), .CMP_LAT(1)) dut1 (
        .iClk(clk), .iRst(rst), .iStart(start1), .iCmp(cmp1), .oGuess(g1), .oBusy(b1),
        .oDone(d1), .oResult(r1), .oSteps(s1), .oErr(e1));

    sar_compare_search #(.WIDTH(8), .CMP_LAT(3)) dut3 (
        .iClk(clk), .iRst(rst), .iStart(start3), .iCmp(cmp3), .oGuess(g3), .oBusy(b3),
        .oDone(d3), .oResult(r3), .oSteps(s3), .oErr(e3));

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts a search on the selected searcher; returns the cycle (1 = cycle after the
    // start sampling edge) in which oDone is seen, or -1 if it never arrives.
    task automatic runSearch(input logic useLat3, input logic [7:0] target,
                             input int midStart, output int doneCyc);
        sel = useLat3;
        tgt = target;
        guessLog.delete();
        @(negedge clk);
        if (useLat3) start3 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start3 = 1'b0;
        doneCyc = 1;
        while (!dS && doneCyc < 200) begin
            if (bS) guessLog.push_back(gS);
            if (doneCyc == midStart) begin
                if (useLat3) start3 = 1'b1; else start1 = 1'b1;
            end else begin
                start1 = 1'b0;
                start3 = 1'b0;
            end
            @(negedge clk);
            doneCyc++;
        end
        start1 = 1'b0;
        start3 = 1'b0;
        if (!dS) doneCyc = -1;
    endtask

    typedef struct {
        logic       lat3;
        logic [7:0] target;
        logic [7:0] expResult;
        int         expSteps;
        int         expCycle;
    } vec_t;

    vec_t       vecs[7];
    logic [7:0] seq5A[8];
    logic [7:0] seq3C[8];
    int         cyc;
    int         nTrials;
    int         doneSeen;

    initial begin
        vecs[0] = '{1'b0, 8'h00, 8'h00, 8, 9};
        vecs[1] = '{1'b0, 8'hFF, 8'hFF, 8, 9};
        vecs[2] = '{1'b0, 8'h5A, 8'h5A, EE ? 7 : 8, EE ? 8 : 9};
        vecs[3] = '{1'b0, 8'h80, 8'h80, EE ? 1 : 8, EE ? 2 : 9};
        vecs[4] = '{1'b0, 8'h01, 8'h01, 8, 9};
        vecs[5] = '{1'b0, 8'h7F, 8'h7F, 8, 9};
        vecs[6] = '{1'b1, 8'h3C, 8'h3C, EE ? 6 : 8, EE ? 19 : 25};
        seq5A = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h58, 8'h5C, 8'h5A, 8'h5B};
        seq3C = '{8'h80, 8'h40, 8'h20, 8'h30, 8'h38, 8'h3C, 8'h3E, 8'h3D};

        rst = 1'b1; start1 = 1'b0; start3 = 1'b0; badCmp = 1'b0; sel = 1'b0; tgt = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_guess1", g1, 0);  check("rst_result1", r1, 0);
        check("rst_steps1", s1, 0);  check("rst_flags1", {b1, d1, e1}, 0);
        check("rst_guess3", g3, 0);  check("rst_flags3", {b3, d3, e3, s3}, 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            runSearch(vecs[i].lat3, vecs[i].target, 0, cyc);
            check($sformatf("v%0d_cycle", i), cyc, vecs[i].expCycle);
            check($sformatf("v%0d_result", i), rS, vecs[i].expResult);
            check($sformatf("v%0d_steps", i), sS, vecs[i].expSteps);
            check($sformatf("v%0d_err", i), eS, 0);
            if (vecs[i].target == 8'h5A) begin
                check("seq5A_len", guessLog.size(), vecs[i].expSteps);
                for (int k = 0; k < guessLog.size() && k < 8; k++)
                    check($sformatf("seq5A_%0d", k), guessLog[k], seq5A[k]);
            end
            if (vecs[i].lat3) begin
                nTrials = vecs[i].expSteps;
                check("seq3C_len", guessLog.size(), nTrials * 3);
                for (int k = 0; k < guessLog.size() && k < 24; k++)
                    check($sformatf("seq3C_%0d", k), guessLog[k], seq3C[k / 3]);
            end
        end

        // result/steps hold after the done pulse
        sel = 1'b1;
        repeat (3) @(negedge clk);
        check("hold_done", dS, 0);
        check("hold_result", rS, 8'h3C);
        check("hold_steps", sS, EE ? 6 : 8);

        // invalid code on the third trial
        sel = 1'b0; tgt = 8'h5A;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        @(negedge clk);
        @(negedge clk); badCmp = 1'b1;
        @(negedge clk); badCmp = 1'b0;
        check("err_done", d1, 1);
        check("err_flag", e1, 1);
        check("err_result", r1, 0);
        check("err_steps", s1, 3);
        @(negedge clk);
        check("err_pulse_once", d1, 0);
        check("err_held", e1, 1);
        start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        check("err_cleared", e1, 0);
        check("restart_busy", b1, 1);
        cyc = 1;
        while (!d1 && cyc < 50) begin @(negedge clk); cyc++; end
        check("restart_cycle", cyc, EE ? 8 : 9);
        check("restart_result", r1, 8'h5A);

        // start during a search is ignored
        runSearch(1'b0, 8'hC3, 4, cyc);
        check("mid_cycle", cyc, 9);
        check("mid_result", r1, 8'hC3);
        check("mid_steps", s1, 8);

        // reset during the fourth trial
        sel = 1'b0; tgt = 8'h5A;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("mrst_guess", g1, 0);
        check("mrst_result", r1, 0);
        check("mrst_steps", s1, 0);
        check("mrst_flags", {b1, d1, e1}, 0);
        doneSeen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (d1 || b1) doneSeen++;
        end
        check("mrst_no_done", doneSeen, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
